adder: RTL and testbench

- Registered WIDTH-bit binary adder with carry-in and carry-out; default is a 4-bit unsigned add A + B + Cin.
- Sits in the datapath as a single-cycle arithmetic stage with valid qualification and status flags (zero, signed overflow).
- Operands are sampled on a clock edge; results appear one cycle later.

---
 rtl/adder.sv | 101 ++++++++++
 tb/tb_adder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder.sv
// ---------------------------------------------------------------------------
// adder: registered WIDTH-bit binary adder with carry-in/carry-out, valid
// qualification and status flags (zero, two's-complement overflow).
//
// Operands are sampled on a rising clk edge when in_valid is high; the result
// appears one cycle later with out_valid high. Cycles without in_valid drop
// out_valid and leave the result registers untouched.
//
// Optional feature (macro ADDER_SUB_EN): adds a 'sub' input. When sub=1 the
// stage computes A - B (B inverted, carry-in forced to 1); Cout=1 then means
// "no borrow".
//
// Parameters:
//   WIDTH      operand/sum width in bits (1..64), default 4
// Ports:
//   clk        in   system clock, rising-edge
//   rst        in   synchronous reset, active-high
//   in_valid   in   A/B/Cin (and sub) qualified this cycle
//   A, B       in   WIDTH-bit operands
//   Cin        in   carry-in
//   sub        in   subtract select (only with ADDER_SUB_EN)
//   out_valid  out  C/Cout/zero/ovf hold a new result this cycle
//   C          out  sum bits, (A + B' + Cin') mod 2^WIDTH
//   Cout       out  carry-out (bit WIDTH of the full sum)
//   zero       out  C == 0
//   ovf        out  two's-complement overflow
// ---------------------------------------------------------------------------
module adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  output logic [WIDTH-1:0] C,
  output logic             Cout,
  output logic             zero,
  output logic             ovf
);

  // Effective operand B' and carry-in after the optional subtract mux.
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;
  logic [WIDTH:0]   w_sum;
  logic             w_zero;
  logic             w_ovf;

`ifdef ADDER_SUB_EN
  // A - B == A + ~B + 1; Cin is irrelevant in subtract mode.
  assign w_b_eff   = sub ? ~B : B;
  assign w_cin_eff = sub ? 1'b1 : Cin;
`else
  assign w_b_eff   = B;
  assign w_cin_eff = Cin;
`endif

  // Zero-extend everything to WIDTH+1 so the top bit is the carry-out.
  assign w_sum  = {1'b0, A} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin_eff};
  assign w_zero = (w_sum[WIDTH-1:0] == '0);
  // Overflow: operands share a sign but the result sign differs.
  assign w_ovf  = (A[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);

  logic             r_valid;
  logic [WIDTH-1:0] r_c;
  logic             r_cout;
  logic             r_zero;
  logic             r_ovf;

  // Result registers only load on qualified cycles, so unqualified (possibly
  // X) inputs never reach the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_c     <= '0;
      r_cout  <= 1'b0;
      r_zero  <= 1'b1;
      r_ovf   <= 1'b0;
    end else if (in_valid) begin
      r_valid <= 1'b1;
      r_c     <= w_sum[WIDTH-1:0];
      r_cout  <= w_sum[WIDTH];
      r_zero  <= w_zero;
      r_ovf   <= w_ovf;
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign C         = r_c;
  assign Cout      = r_cout;
  assign zero      = r_zero;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_adder.sv
// ---------------------------------------------------------------------------
// tb_adder: self-checking bench for adder (WIDTH=4). Stimulus is a mix of
// directed plan vectors and $urandom traffic; expectations come from an
// integer-arithmetic reference model held in the bench. Define ADDER_SUB_EN
// to also exercise the subtract mode.
// ---------------------------------------------------------------------------
module tb_adder;
  localparam int unsigned W = 4;
  localparam longint MOD = 64'd1 << W;
  localparam longint SMAX = (64'd1 << (W - 1)) - 1;
  localparam longint SMIN = -(64'sd1 <<< (W - 1));

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef ADDER_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic [W-1:0] c;
  logic         cout;
  logic         zero;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  // Expected observable state after the next edge: {valid, C, Cout, zero, ovf}.
  logic [W+3:0] exp_vec;
  logic [W+3:0] obs_vec;

  adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .A        (a),
    .B        (b),
    .Cin      (cin),
`ifdef ADDER_SUB_EN
    .sub      (sub),
`endif
    .out_valid(out_valid),
    .C        (c),
    .Cout     (cout),
    .zero     (zero),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  assign obs_vec = {out_valid, c, cout, zero, ovf};

  function automatic longint to_signed(input longint u);
    return (u > SMAX) ? u - MOD : u;
  endfunction

  // Reference: plain integer arithmetic on the operand values.
  task automatic ref_op(input longint ua, input longint ub, input longint ucin,
                        input bit s, output logic [W+3:0] res);
    longint full;
    longint sres;
    logic [W-1:0] sum;
    if (s) begin
      full = ua - ub + MOD;  // Cout=1 exactly when no borrow
      sres = to_signed(ua) - to_signed(ub);
    end else begin
      full = ua + ub + ucin;
      sres = to_signed(ua) + to_signed(ub) + ucin;
    end
    sum = W'(full % MOD);
    res = {1'b1, sum, full >= MOD, sum == 0, (sres > SMAX) || (sres < SMIN)};
  endtask

  // Drive inputs for the next edge and advance the model to match.
  task automatic apply(input bit r, input bit v, input logic [W-1:0] ia,
                       input logic [W-1:0] ib, input bit icin, input bit s);
    logic [W+3:0] res;
    rst = r; in_valid = v; a = ia; b = ib; cin = icin;
`ifdef ADDER_SUB_EN
    sub = s;
`endif
    if (r) begin
      exp_vec = {1'b0, {W{1'b0}}, 1'b0, 1'b1, 1'b0};
    end else if (v) begin
      ref_op(longint'(ia), longint'(ib), longint'(icin), s, res);
      exp_vec = res;
    end else begin
      exp_vec[W+3] = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit rnd_sub();
`ifdef ADDER_SUB_EN
    return bit'($urandom_range(0, 1));
`else
    return 1'b0;
`endif
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 1'b1, W'($urandom), W'($urandom), 1'($urandom), rnd_sub());
      step();
      checks++;
      if (obs_vec !== 8'b0_0000_0_1_0) begin
        errors++;
        $display("FAIL reset[%0d]: got %b required %b", i, obs_vec, 8'b0_0000_0_1_0);
      end
    end
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit           cin;
    logic [W+3:0] want;
  } vec_t;

  task automatic test_directed();
    vec_t tbl[4];
    tbl[0] = '{4'd0,  4'd0,  1'b0, 8'b1_0000_0_1_0};
    tbl[1] = '{4'd4,  4'd5,  1'b1, 8'b1_1010_0_0_1};
    tbl[2] = '{4'd10, 4'd11, 1'b0, 8'b1_0101_1_0_1};
    tbl[3] = '{4'd15, 4'd0,  1'b1, 8'b1_0000_1_1_0};
    foreach (tbl[i]) begin
      apply(1'b0, 1'b1, tbl[i].a, tbl[i].b, tbl[i].cin, 1'b0);
      step();
      checks++;
      if (obs_vec !== tbl[i].want) begin
        errors++;
        $display("FAIL directed[%0d] %0d+%0d+%0d: got %b required %b",
                 i, tbl[i].a, tbl[i].b, tbl[i].cin, obs_vec, tbl[i].want);
      end
    end
    // Drop in_valid with different operands: outputs hold, out_valid falls.
    apply(1'b0, 1'b0, 4'd7, 4'd9, 1'b1, 1'b0);
    step();
    checks++;
    if (obs_vec !== 8'b0_0000_1_1_0) begin
      errors++;
      $display("FAIL hold: got %b required %b", obs_vec, 8'b0_0000_1_1_0);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, 1'b1, W'($urandom), W'($urandom), 1'($urandom), rnd_sub());
      step();
      checks++;
      if (obs_vec !== exp_vec || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %b required %b", i, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_reset_midstream();
    apply(1'b0, 1'b1, 4'd4, 4'd5, 1'b1, 1'b0);
    step();
    checks++;
    if (obs_vec !== 8'b1_1010_0_0_1) begin
      errors++;
      $display("FAIL midstream_op1: got %b required %b", obs_vec, 8'b1_1010_0_0_1);
    end
    apply(1'b1, 1'b1, 4'd10, 4'd11, 1'b0, 1'b0);
    step();
    checks++;
    if (obs_vec !== 8'b0_0000_0_1_0) begin
      errors++;
      $display("FAIL midstream_rst: got %b required %b", obs_vec, 8'b0_0000_0_1_0);
    end
    apply(1'b0, 1'b1, 4'd3, 4'd3, 1'b0, 1'b0);
    step();
    checks++;
    if (obs_vec !== 8'b1_0110_0_0_0) begin
      errors++;
      $display("FAIL midstream_op3: got %b required %b", obs_vec, 8'b1_0110_0_0_0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      apply($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
            W'($urandom), W'($urandom), 1'($urandom), rnd_sub());
      step();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL random[%0d] rst=%0b v=%0b a=%0d b=%0d cin=%0b: got %b required %b",
                 i, rst, in_valid, a, b, cin, obs_vec, exp_vec);
      end
    end
  endtask

`ifdef ADDER_SUB_EN
  task automatic test_sub();
    apply(1'b0, 1'b1, 4'd4, 4'd5, 1'b0, 1'b1);
    step();
    checks++;
    if (obs_vec !== 8'b1_1111_0_0_0) begin
      errors++;
      $display("FAIL sub 4-5: got %b required %b", obs_vec, 8'b1_1111_0_0_0);
    end
    apply(1'b0, 1'b1, 4'd5, 4'd5, 1'b1, 1'b1);
    step();
    checks++;
    if (obs_vec !== 8'b1_0000_1_1_0) begin
      errors++;
      $display("FAIL sub 5-5: got %b required %b", obs_vec, 8'b1_0000_1_1_0);
    end
    // 8 - 1 = -8 - 1 overflows in 4-bit two's complement.
    apply(1'b0, 1'b1, 4'd8, 4'd1, 1'b0, 1'b1);
    step();
    checks++;
    if (obs_vec !== 8'b1_0111_1_0_1) begin
      errors++;
      $display("FAIL sub 8-1: got %b required %b", obs_vec, 8'b1_0111_1_0_1);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef ADDER_SUB_EN
    sub = 1'b0;
`endif
    exp_vec = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midstream();
`ifdef ADDER_SUB_EN
    test_sub();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
